// File: rtl/rams_sdp_be_pipe_if.sv
// rtl/rams_sdp_be_pipe_if.sv - port bundle for rams_sdp_be_pipe
//
// Groups the write port (ena, wea, addra, dia) and the read port
// (enb, addrb, dob, dob_vld) of the simple dual-port RAM.
//   master : the user side. It drives the write and read requests and
//            receives the read data.
//   slave  : the RAM side.
interface rams_sdp_be_pipe_if #(
  parameter int D  = 32,
  parameter int A  = 10,
  parameter int BW = 8
);
  localparam int NB = D / BW;

  logic          ena;
  logic [NB-1:0] wea;
  logic [A-1:0]  addra;
  logic [D-1:0]  dia;
  logic          enb;
  logic [A-1:0]  addrb;
  logic [D-1:0]  dob;
  logic          dob_vld;

  modport master (
    output ena, wea, addra, dia, enb, addrb,
    input  dob, dob_vld
  );

  modport slave (
    input  ena, wea, addra, dia, enb, addrb,
    output dob, dob_vld
  );
endinterface

// File: rtl/rams_sdp_be_pipe.sv
// rtl/rams_sdp_be_pipe.sv - simple dual-port RAM with byte enables and a read pipeline
//
// Ports:
//   clk    : clock; all logic updates on the rising edge.
//   rst_n  : asynchronous active-low reset. It clears the read pipeline only.
//            The memory array keeps its contents through reset.
//   mem_if : slave modport.
//            Write side: ena, wea[NB], addra, dia.
//            Read side:  enb, addrb, dob, dob_vld.
// Read data appears RD_LAT edges after issue, with a one-cycle dob_vld pulse.
// dob holds the last read word between results.
// RDW_MODE selects the result of a same-address read/write on one edge:
//   0 : the read returns the old word.
//   1 : the read returns the new lanes merged over the old word.
module rams_sdp_be_pipe #(
  parameter int D        = 32,
  parameter int A        = 10,
  parameter int BW       = 8,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  rams_sdp_be_pipe_if.slave  mem_if
);
  localparam int NB = D / BW;

  generate
    if (D % BW != 0) begin : g_bad_bw
      $error("rams_sdp_be_pipe: D must be a multiple of BW");
    end
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
      $error("rams_sdp_be_pipe: RD_LAT must be 1..3");
    end
  endgenerate

  logic [D-1:0] ram_q [0:(1<<A)-1];
  logic [D-1:0] rd_word_d;
  logic [D-1:0] data_q [RD_LAT];
  logic         vld_q  [RD_LAT];

  // The array is deliberately not reset, so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_if.ena) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_if.wea[i]) ram_q[mem_if.addra][i*BW +: BW] <= mem_if.dia[i*BW +: BW];
      end
    end
  end

  // In write-first mode, a colliding read sees the enabled lanes of dia
  // overlaid on the stored word. In read-first mode it sees the old word.
  always_comb begin
    rd_word_d = ram_q[mem_if.addrb];
    if (RDW_MODE == 1 && mem_if.ena && mem_if.addra == mem_if.addrb) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_if.wea[i]) rd_word_d[i*BW +: BW] = mem_if.dia[i*BW +: BW];
      end
    end
  end

  // Valid bits shift every cycle. A stage's data register loads only when
  // the previous stage holds a valid word, so dob keeps the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        data_q[s] <= '0;
        vld_q[s]  <= 1'b0;
      end
    end else begin
      vld_q[0] <= mem_if.enb;
      if (mem_if.enb) data_q[0] <= rd_word_d;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) data_q[s] <= data_q[s-1];
      end
    end
  end

  assign mem_if.dob     = data_q[RD_LAT-1];
  assign mem_if.dob_vld = vld_q[RD_LAT-1];
endmodule
